nibble_serial_acc16: RTL and testbench
======================================

Name: nibble_serial_acc16

Overview:
- Nibble-serial add/subtract accumulator for the Slipstream datapath.
- Holds a WIDTH-bit accumulator and applies one operand per START.
- Processes one 4-bit nibble per clock through a single 4-bit carry-chained adder cell, registering the carry between nibbles.
- Trades latency for area, in the style of the chipset's nibble-wide arithmetic.
- Sits between the register-file read stage (supplies OPERAND/START) and the flag/write-back logic (consumes ACC, CO, Z, DONE).

Parameters:
- WIDTH, 16, accumulator/operand width; must be a multiple of 4, minimum 4.
- NIBBLES, WIDTH/4, derived local constant; number of serial steps.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RESET  in  1  synchronous active-high reset.
- START  in  1  request one operation; sampled only when BUSY=0.
- OP  in  1  0 = ACC+OPERAND, 1 = ACC-OPERAND; sampled with START.
- CLR  in  1  clear accumulator; sampled only when BUSY=0.
- OPERAND  in  WIDTH  operand; sampled with START.
- ACC  out  WIDTH  committed accumulator value.
- CO  out  1  final carry (add) / not-borrow (sub) of last operation.
- Z  out  1  1 when ACC==0.
- BUSY  out  1  operation in progress.
- DONE  out  1  one-cycle pulse when ACC/CO/Z are updated by an operation.

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high.
- RESET: ACC=0, CO=0, Z=1, BUSY=0, DONE=0, state IDLE, nibble counter 0. An in-flight operation is aborted and no DONE is produced.
- States: IDLE, RUN.
  - IDLE -> RUN on START=1 and CLR=0.
  - RUN -> IDLE after nibble NIBBLES-1.
- START accept (edge t0):
  - Latch OPERAND into op_reg and ACC into work_reg.
  - Latch sub = OP; carry_reg = OP (carry-in 1 for two's-complement subtract).
  - Counter = 0; BUSY=1 from t0.
- RUN, each edge t1..tN (N = NIBBLES):
  - nib = counter. sum5 = work_reg[nib] + (op_reg[nib] XOR {4{sub}}) + carry_reg.
  - Store sum5[3:0] into work_reg[nib]; carry_reg = sum5[4]; counter+1.
- At edge tN:
  - ACC = final work_reg; CO = final carry; Z = (final work_reg == 0).
  - BUSY=0; DONE=1 for exactly one cycle, after tN.
  - Latency: DONE high NIBBLES cycles after the START edge (4 for WIDTH=16).
  - Back-to-back: START may be accepted in the cycle DONE is high.
- ACC, CO and Z hold their old values during RUN. Partial sums are never visible.
- START or CLR while BUSY=1: ignored, not queued.
- CLR in IDLE: ACC=0, CO=0, Z=1 next edge; no DONE pulse.
- CLR and START together in IDLE: CLR wins, START dropped.
- Wrap-around: arithmetic is modulo 2^WIDTH. CO reports the overflow/borrow; no saturation.
- OPERAND/OP changes during RUN have no effect (registered at accept).

Decomposition:
- Shared package slipstream_arith_pkg:
  - typedef acc_state_t {IDLE, RUN}.
  - Constant NIBBLE_W = 4.
  - Function nibble_count(width).
- One sub-module: nibble_addsub4, combinational. Inputs a[3:0], b[3:0], sub, ci; outputs s[3:0], co; inverts b when sub=1.
- The top block holds the FSM, counter, work/op/carry registers and nibble mux/demux.

Test Plan:
- ACC preset to 0x1234 via CLR then ADD 0x1234; then ADD 0x0FFF -> ACC=0x2233, CO=0, Z=0. DONE exactly 4 cycles after START edge; BUSY high during those 4 cycles.
- ACC=0xFFFF, ADD 0x0001 -> ACC=0x0000, CO=1, Z=1. ACC stays 0xFFFF until the DONE cycle.
- ACC=0x0005, SUB 0x0007 -> ACC=0xFFFE, CO=0. Then SUB 0xFFFE -> ACC=0x0000, CO=1, Z=1.
- START with OPERAND=0x0001 pulsed again at cycles t1..t3 of a running ADD -> only one DONE, ACC increases by the first operand only. START in the DONE cycle is accepted.
- RESET asserted at RUN edge t2 -> next cycle ACC=0, CO=0, Z=1, BUSY=0; no DONE ever pulses for the aborted operation.
- In IDLE with ACC=0x00AA, CLR=1 and START=1 same cycle -> ACC=0x0000, Z=1, BUSY stays 0, no DONE.

Source files
------------

// File: rtl/nibble_serial_acc16_pkg.sv
// Shared arithmetic definitions for the Slipstream nibble-serial datapath.
package slipstream_arith_pkg;

    // Width of one serial arithmetic step.
    localparam int NIBBLE_W = 4;

    // Accumulator sequencing states.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } acc_state_t;

    // Number of serial nibble steps needed to cover a word of the given width.
    function automatic int nibble_count(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/nibble_serial_acc16_if.sv
// Operand/result bundle between the register-file read stage and the accumulator.
interface nibble_serial_acc16_if #(
    parameter int WIDTH = 16
);
    logic             START;
    logic             OP;
    logic             CLR;
    logic [WIDTH-1:0] OPERAND;
    logic [WIDTH-1:0] ACC;
    logic             CO;
    logic             Z;
    logic             BUSY;
    logic             DONE;

    // Requester side: issues operations, observes results.
    modport master (
        output START, OP, CLR, OPERAND,
        input  ACC, CO, Z, BUSY, DONE
    );

    // Accumulator side: consumes operations, publishes results.
    modport slave (
        input  START, OP, CLR, OPERAND,
        output ACC, CO, Z, BUSY, DONE
    );
endinterface

// File: rtl/nibble_addsub4.sv
// 4-bit add/subtract cell; subtraction inverts b, the caller supplies carry-in 1.
module nibble_addsub4
    import slipstream_arith_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                sub,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);
    // One-nibble ripple sum with the carry-out taken as the fifth bit.
    always_comb begin
        {co, s} = {1'b0, a} + {1'b0, b ^ {NIBBLE_W{sub}}} + {{NIBBLE_W{1'b0}}, ci};
    end
endmodule

// File: rtl/nibble_serial_acc16.sv
// Nibble-serial add/subtract accumulator: one 4-bit adder cell reused per clock,
// carry held in a register between nibbles; results commit only at the end.
module nibble_serial_acc16
    import slipstream_arith_pkg::*;
#(
    parameter int WIDTH = 16  // multiple of NIBBLE_W, at least NIBBLE_W
) (
    input  logic                 CLK,
    input  logic                 RESET,
    nibble_serial_acc16_if.slave bus
);
    localparam int NIBBLES = nibble_count(WIDTH);
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    acc_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] op_q;
    logic [WIDTH-1:0] acc_q;
    logic             sub_q;
    logic             carry_q;
    logic             co_q;
    logic             z_q;
    logic             busy_q;
    logic             done_q;

    logic [NIBBLE_W-1:0] work_nib [NIBBLES];
    logic [NIBBLE_W-1:0] op_nib   [NIBBLES];
    logic [NIBBLE_W-1:0] cell_s;
    logic                cell_co;
    logic [WIDTH-1:0]    work_d;

    // Split the working and operand words into nibble lanes, and write the
    // adder result back into whichever lane the counter currently selects.
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_lane
            assign work_nib[gi] = work_q[gi*NIBBLE_W +: NIBBLE_W];
            assign op_nib[gi]   = op_q[gi*NIBBLE_W +: NIBBLE_W];
            assign work_d[gi*NIBBLE_W +: NIBBLE_W] =
                (cnt_q == CNT_W'(gi)) ? cell_s : work_q[gi*NIBBLE_W +: NIBBLE_W];
        end
    endgenerate

    nibble_addsub4 u_cell (
        .a   (work_nib[cnt_q]),
        .b   (op_nib[cnt_q]),
        .sub (sub_q),
        .ci  (carry_q),
        .s   (cell_s),
        .co  (cell_co)
    );

    // Sequencer: accept/clear in IDLE, one nibble per edge in RUN, commit at the last nibble.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            z_q     <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.CLR) begin
                        // Clear takes priority; a simultaneous START is dropped.
                        acc_q <= '0;
                        co_q  <= 1'b0;
                        z_q   <= 1'b1;
                    end else if (bus.START) begin
                        op_q    <= bus.OPERAND;
                        work_q  <= acc_q;
                        sub_q   <= bus.OP;
                        carry_q <= bus.OP;  // +1 completes two's-complement subtract
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    work_q  <= work_d;
                    carry_q <= cell_co;
                    if (cnt_q == CNT_W'(NIBBLES - 1)) begin
                        acc_q   <= work_d;
                        co_q    <= cell_co;
                        z_q     <= (work_d == '0);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ACC  = acc_q;
    assign bus.CO   = co_q;
    assign bus.Z    = z_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
endmodule

// File: tb/tb_nibble_serial_acc16.sv
// Directed test of the nibble-serial accumulator with hand-computed results.
module tb_nibble_serial_acc16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    nibble_serial_acc16_if #(.WIDTH(16)) bus ();

    nibble_serial_acc16 #(.WIDTH(16)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_out(input string tag, input logic [15:0] acc, input logic co,
                             input logic z, input logic busy, input logic done);
        check({tag, ".acc"},  {16'h0, bus.ACC}, {16'h0, acc});
        check({tag, ".co"},   {31'h0, bus.CO},  {31'h0, co});
        check({tag, ".z"},    {31'h0, bus.Z},   {31'h0, z});
        check({tag, ".busy"}, {31'h0, bus.BUSY}, {31'h0, busy});
        check({tag, ".done"}, {31'h0, bus.DONE}, {31'h0, done});
    endtask

    // Clear the accumulator from IDLE.
    task automatic do_clr(input string tag);
        bus.CLR = 1'b1;
        tick();
        bus.CLR = 1'b0;
        check_out(tag, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Full operation: accepted at t0, results unchanged through t3, commit with DONE at t4.
    task automatic do_op(input string tag, input logic op, input logic [15:0] operand,
                         input logic [15:0] exp_acc, input logic exp_co, input logic exp_z);
        logic [15:0] old_acc;
        logic        old_co;
        logic        old_z;
        old_acc = bus.ACC;
        old_co  = bus.CO;
        old_z   = bus.Z;
        bus.START   = 1'b1;
        bus.OP      = op;
        bus.OPERAND = operand;
        tick();
        bus.START = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_out($sformatf("%s.run%0d", tag, k), old_acc, old_co, old_z, 1'b1, 1'b0);
            tick();
        end
        check_out({tag, ".done"}, exp_acc, exp_co, exp_z, 1'b0, 1'b1);
        $display("op %s: op=%0d operand=%h -> acc=%h co=%0d z=%0d", tag, op, operand,
                 bus.ACC, bus.CO, bus.Z);
    endtask

    initial begin
        bus.START   = 1'b0;
        bus.OP      = 1'b0;
        bus.CLR     = 1'b0;
        bus.OPERAND = 16'h0;

        // Reset state
        tick();
        tick();
        check_out("reset", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        // Preset 0x1234, then add 0x0FFF
        do_clr("clr1");
        do_op("add1234", 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b0);
        do_op("add0fff", 1'b0, 16'h0FFF, 16'h2233, 1'b0, 1'b0);
        tick();
        check("done_one_cycle", {31'h0, bus.DONE}, 32'h0);

        // Wrap: 0xFFFF + 1
        do_clr("clr2");
        do_op("addffff", 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        do_op("wrap", 1'b0, 16'h0001, 16'h0000, 1'b1, 1'b1);

        // Subtract with borrow, then exact cancel
        do_clr("clr3");
        do_op("add5", 1'b0, 16'h0005, 16'h0005, 1'b0, 1'b0);
        do_op("sub7", 1'b1, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
        do_op("subfffe", 1'b1, 16'hFFFE, 16'h0000, 1'b1, 1'b1);

        // START re-pulsed during RUN is ignored; START in the DONE cycle is accepted
        bus.START   = 1'b1;
        bus.OP      = 1'b0;
        bus.OPERAND = 16'h0010;
        tick();
        bus.OPERAND = 16'h0001;
        bus.OP      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check_out($sformatf("ign.run%0d", k), 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
            tick();
        end
        bus.START = 1'b0;
        bus.OP    = 1'b0;
        check_out("ign.run3", 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check_out("ign.done", 16'h0010, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.START   = 1'b1;
        bus.OPERAND = 16'h0001;
        tick();
        bus.START = 1'b0;
        check_out("b2b.accept", 16'h0010, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        check_out("b2b.run3", 16'h0010, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_out("b2b.done", 16'h0011, 1'b0, 1'b0, 1'b0, 1'b1);
        $display("op b2b: acc=%h", bus.ACC);

        // CLR while busy is ignored
        bus.START   = 1'b1;
        bus.OPERAND = 16'h0100;
        tick();
        bus.START = 1'b0;
        bus.CLR   = 1'b1;
        tick();
        bus.CLR = 1'b0;
        tick();
        tick();
        tick();
        check_out("clrbusy.done", 16'h0111, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset at RUN edge t2 aborts the operation without a DONE
        bus.START   = 1'b1;
        bus.OPERAND = 16'h0100;
        tick();
        bus.START = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_out("abort", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_out($sformatf("abort.after%0d", k), 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        $display("op abort: acc=%h busy=%0d", bus.ACC, bus.BUSY);

        // CLR and START together in IDLE: clear wins
        do_op("addaa", 1'b0, 16'h00AA, 16'h00AA, 1'b0, 1'b0);
        bus.CLR     = 1'b1;
        bus.START   = 1'b1;
        bus.OPERAND = 16'h0055;
        tick();
        bus.CLR   = 1'b0;
        bus.START = 1'b0;
        check_out("clrstart", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_out($sformatf("clrstart.after%0d", k), 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        $display("op clrstart: acc=%h z=%0d", bus.ACC, bus.Z);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
